// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU codes,
// mux selects, FSM states and the decoded-instruction payload.
package mips_multicycle_ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [OP_W-1:0] OP_OTHER0 = 6'h00;
    localparam logic [OP_W-1:0] OP_J      = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'h0a;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'h0c;
    localparam logic [OP_W-1:0] OP_ORI    = 6'h0d;
    localparam logic [OP_W-1:0] OP_XORI   = 6'h0e;
    localparam logic [OP_W-1:0] OP_LUI    = 6'h0f;
    localparam logic [OP_W-1:0] OP_LW     = 6'h23;
    localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
    localparam logic [OP_W-1:0] OP_SB     = 6'h28;
    localparam logic [OP_W-1:0] OP_SW     = 6'h2b;

    localparam logic [OP_W-1:0] OP0_JR    = 6'h08;
    localparam logic [OP_W-1:0] OP0_ADD   = 6'h20;
    localparam logic [OP_W-1:0] OP0_SUB   = 6'h22;
    localparam logic [OP_W-1:0] OP0_AND   = 6'h24;
    localparam logic [OP_W-1:0] OP0_OR    = 6'h25;
    localparam logic [OP_W-1:0] OP0_XOR   = 6'h26;
    localparam logic [OP_W-1:0] OP0_NOR   = 6'h27;
    localparam logic [OP_W-1:0] OP0_SLT   = 6'h2a;
    localparam logic [OP_W-1:0] OP0_ADDM  = 6'h2c;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'h2;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'h3;
    localparam logic [ALU_W-1:0] ALU_AND = 3'h4;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'h5;
    localparam logic [ALU_W-1:0] ALU_NOR = 3'h6;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'h7;

    localparam logic [SEL_W-1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SRC_RS     = 2'd3;

    localparam logic [SEL_W-1:0] WB_SRC_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_SRC_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_SRC_LUI = 2'd2;
    localparam logic [SEL_W-1:0] WB_SRC_SLT = 2'd3;

    typedef enum logic [ST_W-1:0] {
        ST_START    = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_ADDM_MEM = 3'd6,
        ST_TRAP     = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_LUI, CLS_SLT, CLS_LW, CLS_LBU, CLS_SW, CLS_SB,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_JR, CLS_ADDM, CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             alu_src2;
        logic             rd_src;
        logic             except;
        op_class_e        op_class;
    } decode_t;

    function automatic logic is_req_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM) || (s == ST_ADDM_MEM);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational instruction decoder: ALU op, operand/destination selects,
// illegal-instruction flag and an operation class for the sequencer.
module mips_multicycle_ctrl_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    output decode_t         dec_c
);

    always_comb begin
        dec_c.alu_op   = ALU_ADD;
        dec_c.alu_src2 = 1'b0;
        dec_c.rd_src   = 1'b0;
        dec_c.except   = 1'b0;
        dec_c.op_class = CLS_ALU;
        case (opcode)
            OP_OTHER0: begin
                case (funct)
                    OP0_ADD:  dec_c.alu_op = ALU_ADD;
                    OP0_SUB:  dec_c.alu_op = ALU_SUB;
                    OP0_AND:  dec_c.alu_op = ALU_AND;
                    OP0_OR:   dec_c.alu_op = ALU_OR;
                    OP0_XOR:  dec_c.alu_op = ALU_XOR;
                    OP0_NOR:  dec_c.alu_op = ALU_NOR;
                    OP0_SLT:  begin dec_c.alu_op = ALU_SUB; dec_c.op_class = CLS_SLT; end
                    OP0_JR:   dec_c.op_class = CLS_JR;
                    OP0_ADDM: dec_c.op_class = CLS_ADDM;
                    default:  begin dec_c.except = 1'b1; dec_c.op_class = CLS_ILLEGAL; end
                endcase
            end
            OP_ADDI: begin dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; end
            OP_SLTI: begin
                dec_c.alu_op   = ALU_SUB;
                dec_c.alu_src2 = 1'b1;
                dec_c.rd_src   = 1'b1;
                dec_c.op_class = CLS_SLT;
            end
            OP_ANDI: begin dec_c.alu_op = ALU_AND; dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; end
            OP_ORI:  begin dec_c.alu_op = ALU_OR;  dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; end
            OP_XORI: begin dec_c.alu_op = ALU_XOR; dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; end
            OP_LUI:  begin dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; dec_c.op_class = CLS_LUI; end
            OP_LW:   begin dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; dec_c.op_class = CLS_LW; end
            OP_LBU:  begin dec_c.alu_src2 = 1'b1; dec_c.rd_src = 1'b1; dec_c.op_class = CLS_LBU; end
            OP_SW:   begin dec_c.alu_src2 = 1'b1; dec_c.op_class = CLS_SW; end
            OP_SB:   begin dec_c.alu_src2 = 1'b1; dec_c.op_class = CLS_SB; end
            OP_BEQ:  begin dec_c.alu_op = ALU_SUB; dec_c.op_class = CLS_BEQ; end
            OP_BNE:  begin dec_c.alu_op = ALU_SUB; dec_c.op_class = CLS_BNE; end
            OP_J:    dec_c.op_class = CLS_J;
            default: begin dec_c.except = 1'b1; dec_c.op_class = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, memory-wait timeout counter and
// per-state gating of the decoder's strobes.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OP_W-1:0]   opcode,
    input  logic [OP_W-1:0]   funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_read,
    output logic              word_we,
    output logic              byte_we,
    output logic              ir_we,
    output logic              pc_we,
    output logic [SEL_W-1:0]  pc_src,
    output logic [ALU_W-1:0]  alu_op,
    output logic              alu_src2,
    output logic              rd_src,
    output logic [SEL_W-1:0]  wb_src,
    output logic              writeenable,
    output logic              except,
    output logic [ST_W-1:0]   state
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    decode_t            dec;
    logic               timeout;
    logic               is_load;
    logic               mem_req_d, mem_read_d, word_we_d, byte_we_d;
    logic               writeenable_d, except_d;
    logic [SEL_W-1:0]   wb_src_d;

    mips_multicycle_ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec_c  (dec)
    );

    assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign is_load = (dec.op_class == CLS_LW) || (dec.op_class == CLS_LBU);

    // Next state and wait counter; a ready in the timeout cycle still completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_START: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                if (dec.except)                                              state_d = ST_TRAP;
                else if ((dec.op_class == CLS_J) || (dec.op_class == CLS_JR)) state_d = ST_FETCH;
                else                                                         state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (dec.op_class)
                    CLS_BEQ, CLS_BNE:               state_d = ST_FETCH;
                    CLS_LW, CLS_LBU, CLS_SW, CLS_SB: state_d = ST_MEM;
                    CLS_ADDM:                       state_d = ST_ADDM_MEM;
                    default:                        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready)    state_d = is_load ? ST_WB : ST_FETCH;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_ADDM_MEM: begin
                if (mem_ready)    state_d = ST_WB;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_TRAP;
        endcase
        if (is_req_state(state_q) && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
        if (is_req_state(state_d) && (state_d != state_q)) cnt_d = '0;
    end

    // Registered strobes are derived from the state being entered.
    always_comb begin
        mem_req_d     = is_req_state(state_d);
        mem_read_d    = (state_d == ST_FETCH) || (state_d == ST_ADDM_MEM) ||
                        ((state_d == ST_MEM) && is_load);
        word_we_d     = (state_d == ST_MEM) && (dec.op_class == CLS_SW);
        byte_we_d     = (state_d == ST_MEM) && (dec.op_class == CLS_SB);
        writeenable_d = (state_d == ST_WB);
        except_d      = (state_d == ST_TRAP);
        wb_src_d      = WB_SRC_ALU;
        if (state_d == ST_WB) begin
            case (dec.op_class)
                CLS_LW, CLS_LBU: wb_src_d = WB_SRC_MEM;
                CLS_LUI:         wb_src_d = WB_SRC_LUI;
                CLS_SLT:         wb_src_d = WB_SRC_SLT;
                default:         wb_src_d = WB_SRC_ALU;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_START;
            cnt_q       <= '0;
            mem_req     <= 1'b0;
            mem_read    <= 1'b0;
            word_we     <= 1'b0;
            byte_we     <= 1'b0;
            writeenable <= 1'b0;
            except      <= 1'b0;
            wb_src      <= WB_SRC_ALU;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req     <= mem_req_d;
            mem_read    <= mem_read_d;
            word_we     <= word_we_d;
            byte_we     <= byte_we_d;
            writeenable <= writeenable_d;
            except      <= except_d;
            wb_src      <= wb_src_d;
        end
    end

    // PC/IR writes act on this cycle's ready/zero, so they stay combinational.
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_PC4;
        alu_op   = '0;
        alu_src2 = 1'b0;
        rd_src   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_op = ALU_ADD;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            ST_DECODE: begin
                alu_op   = dec.alu_op;
                alu_src2 = dec.alu_src2;
                rd_src   = dec.rd_src;
                if (dec.op_class == CLS_J) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                end else if (dec.op_class == CLS_JR) begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_RS;
                end
            end
            ST_EXEC: begin
                alu_op   = dec.alu_op;
                alu_src2 = dec.alu_src2;
                rd_src   = dec.rd_src;
                if (dec.op_class == CLS_BEQ) begin
                    pc_we  = zero;
                    pc_src = PC_SRC_BRANCH;
                end else if (dec.op_class == CLS_BNE) begin
                    pc_we  = !zero;
                    pc_src = PC_SRC_BRANCH;
                end
            end
            ST_MEM, ST_WB: begin
                alu_op   = dec.alu_op;
                alu_src2 = dec.alu_src2;
                rd_src   = dec.rd_src;
            end
            ST_ADDM_MEM: begin
                alu_op = ALU_ADD;
                rd_src = dec.rd_src;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
